// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock-divider / reset-sequencing block.
package clk_rst_pkg;

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_SYNC = 2'd1,
      S_SEQ  = 2'd2,
      S_RUN  = 2'd3
   } seq_state_t;

   localparam int unsigned RATIO_MIN = 2;

   localparam logic RST_N_ASSERTED = 1'b0;
   localparam logic DIV_CLK_RST    = 1'b0;
   localparam logic TICK_RST       = 1'b0;
   localparam logic SEQ_DONE_RST   = 1'b0;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: wrap-sampled ratio/enable, registered divided clock and tick.
// Outputs are computed from next-state so each is a plain flop with no input-to-output path.
module clk_div_ch
   import clk_rst_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk_in,
   input  logic             rst_async,
   input  logic             ch_rst_n,
   input  logic [CNT_W-1:0] ratio,
   input  logic             en,
   input  logic             align,
   output logic             clk_div,
   output logic             tick
);

   function automatic logic [CNT_W-1:0] eff_ratio(input logic [CNT_W-1:0] r);
      return (r < CNT_W'(RATIO_MIN)) ? CNT_W'(RATIO_MIN) : r;
   endfunction

   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [CNT_W-1:0] ratio_q, ratio_nxt;
   logic             run_q, run_nxt;

   // Ratio and enable are only taken at a period boundary, so a period is never cut short.
   always_comb begin
      cnt_nxt   = cnt_q;
      ratio_nxt = ratio_q;
      run_nxt   = run_q;
      if (!ch_rst_n) begin
         cnt_nxt   = '0;
         ratio_nxt = eff_ratio(ratio);
         run_nxt   = 1'b0;
      end else if (run_q && align) begin
         cnt_nxt   = '0;
         ratio_nxt = eff_ratio(ratio);
      end else if (!run_q || (cnt_q == ratio_q - CNT_W'(1))) begin
         cnt_nxt = '0;
         run_nxt = en;
         if (en) begin
            ratio_nxt = eff_ratio(ratio);
         end
      end else begin
         cnt_nxt = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or posedge rst_async) begin
      if (rst_async) begin
         cnt_q   <= '0;
         ratio_q <= CNT_W'(RATIO_MIN);
         run_q   <= 1'b0;
         clk_div <= DIV_CLK_RST;
         tick    <= TICK_RST;
      end else begin
         cnt_q   <= cnt_nxt;
         ratio_q <= ratio_nxt;
         run_q   <= run_nxt;
         clk_div <= run_nxt && (cnt_nxt < (ratio_nxt >> 1));
         tick    <= run_nxt && (cnt_nxt == '0);
      end
   end

endmodule

// File: rtl/clk_div_rst_gen.sv
// Clock-divider bank with synchronised global reset and staggered per-channel reset release.
// Optional build macro CLK_DIV_RST_GEN_PHASE_ALIGN_EN enables align_i phase realignment in S_RUN.
module clk_div_rst_gen
   import clk_rst_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int RST_GAP     = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_async,
   input  logic [N_CH*CNT_W-1:0] div_ratio_i,
   input  logic [N_CH-1:0]       div_en_i,
   input  logic                  align_i,
   output logic [N_CH-1:0]       clk_div_o,
   output logic [N_CH-1:0]       clk_tick_o,
   output logic                  rst_sync_n_o,
   output logic [N_CH-1:0]       rst_ch_n_o,
   output logic                  seq_done_o
);

   localparam int GAP_W = (RST_GAP > 1) ? $clog2(RST_GAP) : 1;
   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   seq_state_t             state_q, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [GAP_W-1:0]       gap_q, gap_nxt;
   logic [IDX_W-1:0]       idx_q, idx_nxt;
   logic [N_CH-1:0]        rst_ch_nxt;
   logic                   done_nxt;
   logic                   align_act;

   // Asynchronous assert, synchronous deassert of the global reset.
   always_ff @(posedge clk_in or posedge rst_async) begin
      if (rst_async) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_sync_n_o = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_in or posedge rst_async) begin
      if (rst_async) begin
         state_q    <= S_RST;
         gap_q      <= '0;
         idx_q      <= '0;
         rst_ch_n_o <= {N_CH{RST_N_ASSERTED}};
         seq_done_o <= SEQ_DONE_RST;
      end else begin
         state_q    <= state_nxt;
         gap_q      <= gap_nxt;
         idx_q      <= idx_nxt;
         rst_ch_n_o <= rst_ch_nxt;
         seq_done_o <= done_nxt;
      end
   end

   // Channel 0 leaves reset on the same edge as the global reset; the rest follow RST_GAP apart.
   always_comb begin
      state_nxt  = state_q;
      gap_nxt    = gap_q;
      idx_nxt    = idx_q;
      rst_ch_nxt = rst_ch_n_o;
      done_nxt   = seq_done_o;
      unique case (state_q)
         S_RST: state_nxt = S_SYNC;
         S_SYNC: begin
            if (sync_q[SYNC_STAGES-2]) begin
               rst_ch_nxt[0] = 1'b1;
               gap_nxt       = '0;
               idx_nxt       = IDX_W'(1);
               if (N_CH == 1) begin
                  state_nxt = S_RUN;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_SEQ;
               end
            end
         end
         S_SEQ: begin
            if (gap_q == GAP_W'(RST_GAP - 1)) begin
               rst_ch_nxt[idx_q] = 1'b1;
               gap_nxt           = '0;
               idx_nxt           = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(N_CH - 1)) begin
                  state_nxt = S_RUN;
                  done_nxt  = 1'b1;
               end
            end else begin
               gap_nxt = gap_q + GAP_W'(1);
            end
         end
         S_RUN: done_nxt = 1'b1;
         default: state_nxt = S_RST;
      endcase
   end

`ifdef CLK_DIV_RST_GEN_PHASE_ALIGN_EN
   assign align_act = align_i && (state_q == S_RUN);
`else
   logic unused_align;
   assign unused_align = align_i;
   assign align_act    = 1'b0;
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      clk_div_ch #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk_in    (clk_in),
         .rst_async (rst_async),
         .ch_rst_n  (rst_ch_n_o[i]),
         .ratio     (div_ratio_i[i*CNT_W +: CNT_W]),
         .en        (div_en_i[i]),
         .align     (align_act),
         .clk_div   (clk_div_o[i]),
         .tick      (clk_tick_o[i])
      );
   end

endmodule
